bin_to_digits: RTL and testbench

BIN_TO_DIGITS -- requirements
Module: bin_to_digits

---
 rtl/bin_to_digits.sv | 154 +++++++++++++++
 tb/tb_bin_to_digits.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bin_to_digits.sv
// bin_to_digits
//   Converts an 8-bit binary value into four 4-bit digit codes for
//   7-segment decoders. It uses a sequential double-dabble: one iteration
//   per clock, 8 iterations in total, then one formatting cycle.
//   Digit codes: 0-9 are decimal digits, 10 is minus, 15 is blank.
//
// Parameters
//   SIGNED   : 1 = value is two's complement, 0 = value is unsigned
//   BLANK_LZ : 1 = leading-zero digits are shown as blank (15)
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   conversion request, only looked at in IDLE
//   value[7:0] in   number to convert, captured on the accepting edge
//   busy       out  high while SHIFT/FORMAT are in progress
//   done       out  one-cycle pulse when new digits are presented
//   dig3..dig0 out  digit codes, dig0 = units
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; digits hold the last result
// SHIFT  | one double-dabble iteration per edge, 8 edges
// FORMAT | blanking/minus placement, digits registered, done pulsed

module bin_to_digits #(
    parameter int SIGNED   = 1,
    parameter int BLANK_LZ = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] value,
    output logic       busy,
    output logic       done,
    output logic [3:0] dig3,
    output logic [3:0] dig2,
    output logic [3:0] dig1,
    output logic [3:0] dig0
);

    localparam logic [3:0] CODE_MINUS = 4'd10;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FORMAT = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] mag;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] units;
    logic [2:0] iter;
    logic       neg;

    logic [7:0] mag_in;
    logic       neg_in;
    logic [3:0] fmt3, fmt2, fmt1, fmt0;
    logic [3:0] sign_code;

    function automatic logic [3:0] dabble(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // -128 negates to 8'h80, which read as unsigned is the required 128.
    always_comb begin
        mag_in = value;
        neg_in = 1'b0;
        if (SIGNED != 0 && value[7]) begin
            mag_in = ~value + 8'd1;
            neg_in = 1'b1;
        end
    end

    // The minus sign sits just left of the most significant shown digit.
    // Without blanking that digit is always the hundreds position.
    always_comb begin
        sign_code = neg ? CODE_MINUS : CODE_BLANK;
        fmt3      = sign_code;
        fmt2      = hundreds;
        fmt1      = tens;
        fmt0      = units;
        if (BLANK_LZ != 0 && hundreds == 4'd0) begin
            fmt3 = CODE_BLANK;
            if (tens == 4'd0) begin
                fmt2 = CODE_BLANK;
                fmt1 = sign_code;
            end else begin
                fmt2 = sign_code;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            dig3     <= CODE_BLANK;
            dig2     <= CODE_BLANK;
            dig1     <= CODE_BLANK;
            dig0     <= 4'd0;
            mag      <= 8'd0;
            hundreds <= 4'd0;
            tens     <= 4'd0;
            units    <= 4'd0;
            iter     <= 3'd0;
            neg      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SHIFT;
                        busy     <= 1'b1;
                        mag      <= mag_in;
                        neg      <= neg_in;
                        hundreds <= 4'd0;
                        tens     <= 4'd0;
                        units    <= 4'd0;
                        iter     <= 3'd0;
                    end
                end
                SHIFT: begin
                    // With an 8-bit input the hundreds nibble never exceeds 2,
                    // so nothing is lost off the top of the 20-bit shift.
                    {hundreds, tens, units, mag} <=
                        {dabble(hundreds), dabble(tens), dabble(units), mag} << 1;
                    iter <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        state <= FORMAT;
                    end
                end
                FORMAT: begin
                    dig3  <= fmt3;
                    dig2  <= fmt2;
                    dig1  <= fmt1;
                    dig0  <= fmt0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_digits.sv
module tb_bin_to_digits;

    logic       clk;
    logic       rst_n;
    logic       start_s, start_u;
    logic [7:0] value_s, value_u;
    logic       busy_s, busy_u, done_s, done_u;
    logic [3:0] d3_s, d2_s, d1_s, d0_s;
    logic [3:0] d3_u, d2_u, d1_u, d0_u;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] prev_s, prev_u;

    localparam logic [15:0] RESET_DIGITS = 16'hFFF0;

    // signed, leading zeros blanked
    bin_to_digits #(.SIGNED(1), .BLANK_LZ(1)) u_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .value(value_s),
        .busy(busy_s), .done(done_s),
        .dig3(d3_s), .dig2(d2_s), .dig1(d1_s), .dig0(d0_s)
    );

    // unsigned, no blanking
    bin_to_digits #(.SIGNED(0), .BLANK_LZ(0)) u_u (
        .clk(clk), .rst_n(rst_n), .start(start_u), .value(value_u),
        .busy(busy_u), .done(done_u),
        .dig3(d3_u), .dig2(d2_u), .dig1(d1_u), .dig0(d0_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Decimal rendering from plain arithmetic: digits of |v|, then the
    // leftmost non-blank position decides where the sign goes.
    function automatic logic [15:0] ref_digits(input logic [7:0] v, input bit sgn, input bit blk);
        int val, m, ms;
        bit neg;
        int d[4];
        val = int'(v);
        if (sgn && val >= 128) val = val - 256;
        neg  = (val < 0);
        m    = neg ? -val : val;
        d[0] = m % 10;
        d[1] = (m / 10) % 10;
        d[2] = m / 100;
        d[3] = 15;
        ms = 2;
        if (blk) begin
            if (d[2] != 0)      ms = 2;
            else if (d[1] != 0) ms = 1;
            else                ms = 0;
        end
        for (int p = ms + 1; p < 4; p++)
            d[p] = (neg && p == ms + 1) ? 10 : 15;
        return {4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])};
    endfunction

    function automatic logic [15:0] st(input logic b, input logic d);
        return {14'd0, b, d};
    endfunction

    // Start on the coming edge k, then walk through k..k+10 checking busy,
    // done and digit hold; start/value are scrambled while the block is busy.
    task automatic convert(input logic [7:0] vs, input logic [7:0] vu);
        logic [15:0] es, eu;
        es = ref_digits(vs, 1'b1, 1'b1);
        eu = ref_digits(vu, 1'b0, 1'b0);
        start_s = 1'b1; start_u = 1'b1;
        value_s = vs;   value_u = vu;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            chk("run_status_s", st(busy_s, done_s), 16'd2);
            chk("run_status_u", st(busy_u, done_u), 16'd2);
            chk("hold_s", {d3_s, d2_s, d1_s, d0_s}, prev_s);
            chk("hold_u", {d3_u, d2_u, d1_u, d0_u}, prev_u);
            start_s = 1'($urandom); start_u = 1'($urandom);
            value_s = 8'($urandom); value_u = 8'($urandom);
        end
        @(negedge clk);
        chk("done_status_s", st(busy_s, done_s), 16'd1);
        chk("done_status_u", st(busy_u, done_u), 16'd1);
        chk("result_s", {d3_s, d2_s, d1_s, d0_s}, es);
        chk("result_u", {d3_u, d2_u, d1_u, d0_u}, eu);
        start_s = 1'b0; start_u = 1'b0;
        @(negedge clk);
        chk("after_s", st(busy_s, done_s), 16'd0);
        chk("after_u", st(busy_u, done_u), 16'd0);
        chk("keep_s", {d3_s, d2_s, d1_s, d0_s}, es);
        chk("keep_u", {d3_u, d2_u, d1_u, d0_u}, eu);
        prev_s = es;
        prev_u = eu;
    endtask

    initial begin
        logic [15:0] exp_bb;
        rst_n = 1'b0;
        start_s = 1'b0; start_u = 1'b0;
        value_s = 8'h00; value_u = 8'h00;
        prev_s = RESET_DIGITS;
        prev_u = RESET_DIGITS;
        repeat (3) @(negedge clk);

        // reset wins over start on the same edge
        start_s = 1'b1; start_u = 1'b1; value_s = 8'h12; value_u = 8'h34;
        @(negedge clk);
        chk("rst_status_s", st(busy_s, done_s), 16'd0);
        chk("rst_status_u", st(busy_u, done_u), 16'd0);
        chk("rst_digits_s", {d3_s, d2_s, d1_s, d0_s}, RESET_DIGITS);
        chk("rst_digits_u", {d3_u, d2_u, d1_u, d0_u}, RESET_DIGITS);
        start_s = 1'b0; start_u = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_status_s", st(busy_s, done_s), 16'd0);
        chk("idle_digits_s", {d3_s, d2_s, d1_s, d0_s}, RESET_DIGITS);
        chk("idle_digits_u", {d3_u, d2_u, d1_u, d0_u}, RESET_DIGITS);

        // directed values, including the documented examples
        convert(8'hF6, 8'hFF);
        chk("ex_m10", prev_s, 16'hFA10);
        chk("ex_255", prev_u, 16'hF255);
        convert(8'h80, 8'h07);
        chk("ex_m128", prev_s, 16'hA128);
        chk("ex_7", prev_u, 16'hF007);
        convert(8'h05, 8'h00);
        chk("ex_5", prev_s, 16'hFFF5);
        convert(8'h00, 8'h80);
        convert(8'hFB, 8'h64);
        convert(8'h7F, 8'h09);
        convert(8'h9C, 8'h63);
        convert(8'hFF, 8'hC8);

        for (int r = 0; r < 16; r++)
            convert(8'($urandom), 8'($urandom));

        // start held high: new conversion every 10 cycles
        exp_bb = ref_digits(8'h2A, 1'b1, 1'b1);
        start_s = 1'b1; value_s = 8'h2A;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (n % 10 == 9) begin
                chk("bb_status", st(busy_s, done_s), 16'd1);
                chk("bb_result", {d3_s, d2_s, d1_s, d0_s}, exp_bb);
            end else begin
                chk("bb_status", st(busy_s, done_s), 16'd2);
            end
        end
        start_s = 1'b0;
        @(negedge clk);
        chk("bb_end", st(busy_s, done_s), 16'd0);
        prev_s = exp_bb;

        // reset at edge k+5 aborts the conversion
        start_s = 1'b1; start_u = 1'b1; value_s = 8'h7B; value_u = 8'hC8;
        @(negedge clk);
        start_s = 1'b0; start_u = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_status_s", st(busy_s, done_s), 16'd0);
        chk("abort_status_u", st(busy_u, done_u), 16'd0);
        chk("abort_digits_s", {d3_s, d2_s, d1_s, d0_s}, RESET_DIGITS);
        chk("abort_digits_u", {d3_u, d2_u, d1_u, d0_u}, RESET_DIGITS);
        rst_n = 1'b1;
        prev_s = RESET_DIGITS;
        prev_u = RESET_DIGITS;
        convert(8'hD6, 8'h2A);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
